// File: rtl/clk_pkg.sv
// Shared types for the clock board power sequencer: state encoding, registered
// output bundle and small helpers used to size and decode the sequencer.
package clk_pkg;

    localparam int PWR_STATE_W = 3;

    typedef enum logic [PWR_STATE_W-1:0] {
        ST_OFF       = 3'd0,
        ST_OCXO_PWR  = 3'd1,
        ST_PLL_RST   = 3'd2,
        ST_LOCK_WAIT = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } pwr_state_t;

    typedef struct packed {
        logic ocxo_ena;
        logic pll_rst_n;
        logic gps_ena;
        logic dac_ena;
        logic disp_ena;
        logic running;
        logic fault;
    } pwr_out_t;

    // Timing parameters of 0 are treated as 1 so every timed state dwells at least one cycle.
    function automatic int unsigned min1(input int unsigned v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic pwr_out_t decode_out(input pwr_state_t s);
        pwr_out_t o;
        o = '0;
        case (s)
            ST_OCXO_PWR, ST_PLL_RST: o.ocxo_ena = 1'b1;
            ST_LOCK_WAIT: begin
                o.ocxo_ena  = 1'b1;
                o.pll_rst_n = 1'b1;
            end
            ST_RUN: begin
                o.ocxo_ena  = 1'b1;
                o.pll_rst_n = 1'b1;
                o.gps_ena   = 1'b1;
                o.dac_ena   = 1'b1;
                o.disp_ena  = 1'b1;
                o.running   = 1'b1;
            end
            ST_FAULT: begin
                o.ocxo_ena = 1'b1;
                o.fault    = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/delay1.sv
// Fixed-length single-bit register pipeline; with CYCLES=2 it serves as a
// two-flop synchroniser for asynchronous status inputs.
module delay1 #(
    parameter int CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [CYCLES-1:0] pipe_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_q <= '0;
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < CYCLES; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign q_o = pipe_q[CYCLES-1];

endmodule

// File: rtl/pwr_seq.sv
// Power-up sequencer: OCXO warm-up, PLL reset pulse, lock supervision with
// bounded re-lock retries, and a sticky fault that only start=0 clears.
module pwr_seq
    import clk_pkg::*;
#(
    parameter int CTR_W       = 24,
    parameter int OCXO_WARM   = 10_000_000,
    parameter int PLL_RST_CYC = 16,
    parameter int LOCK_TMO    = 1_000_000,
    parameter int LOCK_FILT   = 4,
    parameter int MAX_RETRY   = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   locked,
    output logic                   ocxo_ena,
    output logic                   pll_rst_n,
    output logic                   gps_ena,
    output logic                   dac_ena,
    output logic                   disp_ena,
    output logic                   running,
    output logic                   fault,
    output logic [PWR_STATE_W-1:0] state,
    output logic [1:0]             retries
);

    localparam int LF   = int'(min1(LOCK_FILT));
    localparam int UF_W = $clog2(LF + 1);

    localparam logic [CTR_W-1:0] WARM_LD = CTR_W'(min1(OCXO_WARM) - 1);
    localparam logic [CTR_W-1:0] RST_LD  = CTR_W'(min1(PLL_RST_CYC) - 1);
    localparam logic [CTR_W-1:0] TMO_LD  = CTR_W'(min1(LOCK_TMO) - 1);
    localparam logic [UF_W-1:0]  LF_V    = UF_W'(LF);
    localparam logic [1:0]       RETRY_MAX = 2'(MAX_RETRY);

    pwr_state_t       state_q, state_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [UF_W-1:0]  ufilt_q, ufilt_d;
    logic [1:0]       retries_q, retries_d;
    pwr_out_t         out_q;
    logic             lock_s;

    // A PLL held in reset cannot be locked; qualifying with the reset output also
    // flushes stale lock out of the synchroniser before each lock wait.
    delay1 #(.CYCLES(2)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (locked & out_q.pll_rst_n),
        .q_o   (lock_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_OFF;
            ctr_q     <= '0;
            ufilt_q   <= '0;
            retries_q <= '0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            ufilt_q   <= ufilt_d;
            retries_q <= retries_d;
            out_q     <= decode_out(state_d);
        end
    end

    always_comb begin
        state_d   = state_q;
        ctr_d     = ctr_q;
        ufilt_d   = '0;
        retries_d = retries_q;
        if (!start) begin
            state_d   = ST_OFF;
            ctr_d     = '0;
            retries_d = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d = ST_OCXO_PWR;
                    ctr_d   = WARM_LD;
                end
                ST_OCXO_PWR: begin
                    if (ctr_q == '0) begin
                        state_d = ST_PLL_RST;
                        ctr_d   = RST_LD;
                    end else begin
                        ctr_d = ctr_q - CTR_W'(1);
                    end
                end
                ST_PLL_RST: begin
                    if (ctr_q == '0) begin
                        state_d = ST_LOCK_WAIT;
                        ctr_d   = TMO_LD;
                    end else begin
                        ctr_d = ctr_q - CTR_W'(1);
                    end
                end
                ST_LOCK_WAIT: begin
                    if (lock_s) begin
                        state_d = ST_RUN;
                    end else if (ctr_q == '0) begin
                        state_d = ST_FAULT;
                    end else begin
                        ctr_d = ctr_q - CTR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        ufilt_d = ufilt_q + UF_W'(1);
                        if (ufilt_d == LF_V) begin
                            ufilt_d = '0;
                            if (retries_q < RETRY_MAX) begin
                                retries_d = retries_q + 2'd1;
                                state_d   = ST_PLL_RST;
                                ctr_d     = RST_LD;
                            end else begin
                                state_d = ST_FAULT;
                            end
                        end
                    end
                end
                ST_FAULT: state_d = ST_FAULT;
                default: begin
                    state_d = ST_OFF;
                    ctr_d   = '0;
                end
            endcase
        end
    end

    assign ocxo_ena  = out_q.ocxo_ena;
    assign pll_rst_n = out_q.pll_rst_n;
    assign gps_ena   = out_q.gps_ena;
    assign dac_ena   = out_q.dac_ena;
    assign disp_ena  = out_q.disp_ena;
    assign running   = out_q.running;
    assign fault     = out_q.fault;
    assign state     = state_q;
    assign retries   = retries_q;

endmodule

// File: tb/tb_pwr_seq.sv
// Directed bench for pwr_seq with short timing parameters; expected values are
// cycle counts derived by hand from the sequencing rules.
module tb_pwr_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       locked;
    logic       ocxo_ena, pll_rst_n, gps_ena, dac_ena, disp_ena, running, fault;
    logic [2:0] state;
    logic [1:0] retries;

    int checks = 0;
    int errors = 0;

    pwr_seq #(
        .CTR_W       (24),
        .OCXO_WARM   (20),
        .PLL_RST_CYC (4),
        .LOCK_TMO    (50),
        .LOCK_FILT   (3),
        .MAX_RETRY   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .locked    (locked),
        .ocxo_ena  (ocxo_ena),
        .pll_rst_n (pll_rst_n),
        .gps_ena   (gps_ena),
        .dac_ena   (dac_ena),
        .disp_ena  (disp_ena),
        .running   (running),
        .fault     (fault),
        .state     (state),
        .retries   (retries)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chkn(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // From OFF with locked=1: RUN is reached 28 clocks after start rises.
    task automatic bring_up(input string tag);
        start = 1'b1;
        tick(27);
        chkn({tag, "_pre_run_state"}, {5'd0, state}, 8'd3);
        tick(1);
        chkn({tag, "_run_state"}, {5'd0, state}, 8'd4);
        chk1({tag, "_running"}, running, 1'b1);
    endtask

    // Drop locked for 3 clocks; returns at the clock where the loss is acted on.
    task automatic lose_lock();
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(2);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        locked = 1'b0;
        tick(3);
        chkn("rst_state", {5'd0, state}, 8'd0);
        chk1("rst_ocxo", ocxo_ena, 1'b0);
        chk1("rst_pll_rst_n", pll_rst_n, 1'b0);
        chk1("rst_running", running, 1'b0);
        chkn("rst_retries", {6'd0, retries}, 8'd0);
        rst_n = 1'b1;
        tick(2);

        // 1: full bring-up with lock already present
        locked = 1'b1;
        start  = 1'b1;
        tick(1);
        chk1("t1_ocxo_at_1", ocxo_ena, 1'b1);
        chkn("t1_state_at_1", {5'd0, state}, 8'd1);
        tick(19);
        chkn("t1_state_at_20", {5'd0, state}, 8'd1);
        tick(1);
        chkn("t1_state_at_21", {5'd0, state}, 8'd2);
        chk1("t1_pll_rst_n_at_21", pll_rst_n, 1'b0);
        tick(3);
        chk1("t1_pll_rst_n_at_24", pll_rst_n, 1'b0);
        tick(1);
        chk1("t1_pll_rst_n_at_25", pll_rst_n, 1'b1);
        chkn("t1_state_at_25", {5'd0, state}, 8'd3);
        tick(2);
        chk1("t1_running_at_27", running, 1'b0);
        tick(1);
        chk1("t1_running_at_28", running, 1'b1);
        chk1("t1_gps_at_28", gps_ena, 1'b1);
        chk1("t1_dac_at_28", dac_ena, 1'b1);
        chk1("t1_disp_at_28", disp_ena, 1'b1);

        // 3: 2-clock glitch filtered, 3-clock loss triggers a retry
        locked = 1'b0;
        tick(2);
        locked = 1'b1;
        tick(6);
        chkn("t3_glitch_state", {5'd0, state}, 8'd4);
        chkn("t3_glitch_retries", {6'd0, retries}, 8'd0);
        locked = 1'b0;
        tick(3);
        locked = 1'b1;
        tick(1);
        chkn("t3_loss_pre_state", {5'd0, state}, 8'd4);
        tick(1);
        chkn("t3_loss_state", {5'd0, state}, 8'd2);
        chkn("t3_loss_retries", {6'd0, retries}, 8'd1);
        chk1("t3_loss_pll_rst_n", pll_rst_n, 1'b0);
        chk1("t3_loss_running", running, 1'b0);
        tick(3);
        chk1("t3_rst_last", pll_rst_n, 1'b0);
        tick(1);
        chk1("t3_rst_release", pll_rst_n, 1'b1);
        tick(2);
        chkn("t3_relock_pre", {5'd0, state}, 8'd3);
        tick(1);
        chkn("t3_relock_state", {5'd0, state}, 8'd4);

        // 4: retries exhaust into FAULT; start=0 clears everything
        start = 1'b0;
        tick(1);
        chkn("t4_off_state", {5'd0, state}, 8'd0);
        chkn("t4_off_retries", {6'd0, retries}, 8'd0);
        bring_up("t4_up");
        lose_lock();
        chkn("t4_loss1_retries", {6'd0, retries}, 8'd1);
        chkn("t4_loss1_state", {5'd0, state}, 8'd2);
        tick(7);
        chkn("t4_relock1", {5'd0, state}, 8'd4);
        lose_lock();
        chkn("t4_loss2_retries", {6'd0, retries}, 8'd2);
        chkn("t4_loss2_state", {5'd0, state}, 8'd2);
        tick(7);
        chkn("t4_relock2", {5'd0, state}, 8'd4);
        lose_lock();
        chkn("t4_loss3_state", {5'd0, state}, 8'd5);
        chk1("t4_loss3_fault", fault, 1'b1);
        chk1("t4_loss3_ocxo", ocxo_ena, 1'b1);
        chk1("t4_loss3_pll_rst_n", pll_rst_n, 1'b0);
        chk1("t4_loss3_running", running, 1'b0);
        chkn("t4_loss3_retries", {6'd0, retries}, 8'd2);
        tick(10);
        chk1("t4_fault_sticky", fault, 1'b1);
        start = 1'b0;
        tick(1);
        chkn("t4_clear_state", {5'd0, state}, 8'd0);
        chkn("t4_clear_retries", {6'd0, retries}, 8'd0);
        chk1("t4_clear_fault", fault, 1'b0);
        chk1("t4_clear_ocxo", ocxo_ena, 1'b0);

        // 2: no lock -> FAULT 50 clocks after reset release
        locked = 1'b0;
        start  = 1'b1;
        tick(25);
        chk1("t2_pll_rise", pll_rst_n, 1'b1);
        tick(49);
        chk1("t2_fault_pre", fault, 1'b0);
        tick(1);
        chk1("t2_fault", fault, 1'b1);
        chkn("t2_state", {5'd0, state}, 8'd5);
        chk1("t2_pll_rst_n", pll_rst_n, 1'b0);
        chk1("t2_ocxo", ocxo_ena, 1'b1);

        // 5: abort during warm-up and during lock wait
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(13);
        chkn("t5_mid_warm_state", {5'd0, state}, 8'd1);
        start = 1'b0;
        tick(1);
        chkn("t5_abort1_state", {5'd0, state}, 8'd0);
        chk1("t5_abort1_ocxo", ocxo_ena, 1'b0);
        start = 1'b1;
        tick(1);
        chk1("t5_restart_ocxo", ocxo_ena, 1'b1);
        tick(19);
        chkn("t5_restart_at_20", {5'd0, state}, 8'd1);
        tick(1);
        chkn("t5_restart_at_21", {5'd0, state}, 8'd2);
        tick(4);
        chkn("t5_lock_wait", {5'd0, state}, 8'd3);
        start = 1'b0;
        tick(1);
        chkn("t5_abort2_state", {5'd0, state}, 8'd0);
        chk1("t5_abort2_pll_rst_n", pll_rst_n, 1'b0);
        chk1("t5_abort2_ocxo", ocxo_ena, 1'b0);

        // 6: asynchronous reset while running
        locked = 1'b1;
        bring_up("t6_up");
        #2;
        rst_n = 1'b0;
        #1;
        chkn("t6_async_state", {5'd0, state}, 8'd0);
        chk1("t6_async_ocxo", ocxo_ena, 1'b0);
        chk1("t6_async_running", running, 1'b0);
        chk1("t6_async_gps", gps_ena, 1'b0);
        tick(2);
        rst_n = 1'b1;
        tick(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
